// File: rtl/crc_link_sequencer.sv
// Round-robin sharing of one serial CRC-6 check engine between NLINK buffered links.
// Pops each granted packet bit-serially, steers the engine, then checks the trailing CRC bits.
module crc_link_sequencer #(
    parameter int NLINK = 4,
    parameter int LENW  = 12
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NLINK-1:0]      Req,
    input  logic [NLINK*LENW-1:0] Len,
    input  logic [NLINK-1:0]      Bit,
    output logic [NLINK-1:0]      BitRd,
    output logic                  CrcRst,
    output logic                  CrcStart,
    output logic                  CrcStop,
    output logic                  CrcDin,
    input  logic [5:0]            CrcVal,
    output logic                  Done,
    output logic [2:0]            DoneLink,
    output logic                  CrcErr,
    output logic                  LenErr,
    output logic [15:0]           PktCnt,
    output logic [15:0]           ErrCnt
);
    localparam int GW = (NLINK > 1) ? $clog2(NLINK) : 1;

    typedef enum logic [2:0] {IDLE, ARB, DATA, CRCB, CMP} state_t;

    state_t          r_state, w_next;
    logic [GW-1:0]   r_ptr, r_gnt, w_gnt, w_nptr;
    logic [GW:0]     w_idx;
    logic            w_any;
    logic [LENW-1:0] r_len, w_len;
    logic [LENW:0]   r_cnt;
    logic [5:0]      r_rx;
    logic            r_lenerr;
    logic            w_crcerr;
    logic            w_last;
    logic [15:0]     r_pkt_cnt, r_err_cnt;

    // First requester at or after the pointer: scan offsets high to low so the smallest wins.
    always_comb begin
        w_gnt = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int j = NLINK-1; j >= 0; j--) begin
            w_idx = {1'b0, r_ptr} + (GW+1)'(j);
            if (w_idx >= (GW+1)'(NLINK))
                w_idx = w_idx - (GW+1)'(NLINK);
            if (Req[w_idx[GW-1:0]]) begin
                w_gnt = w_idx[GW-1:0];
                w_any = 1'b1;
            end
        end
    end

    assign w_nptr   = (w_gnt == GW'(NLINK-1)) ? '0 : w_gnt + 1'b1;
    assign w_len    = Len[int'(w_gnt)*LENW +: LENW];
    assign w_last   = (r_cnt == {1'b0, r_len} - 1'b1);
    assign w_crcerr = (r_rx != CrcVal) & ~r_lenerr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (|Req) w_next = ARB;
            ARB: begin
                if (!w_any)            w_next = IDLE;
                else if (w_len == '0)  w_next = CRCB;
                else                   w_next = DATA;
            end
            DATA: if (w_last) w_next = CRCB;
            CRCB: if (r_cnt == (LENW+1)'(5)) w_next = CMP;
            CMP:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_rx      <= '0;
            r_lenerr  <= 1'b0;
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ARB: begin
                    r_cnt <= '0;
                    if (w_any) begin
                        r_gnt    <= w_gnt;
                        r_len    <= w_len;
                        r_lenerr <= (w_len < LENW'(2));
                        r_ptr    <= w_nptr;
                    end
                end
                DATA: r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                CRCB: begin
                    r_rx  <= {r_rx[4:0], Bit[r_gnt]};
                    r_cnt <= r_cnt + 1'b1;
                end
                CMP: begin
                    r_pkt_cnt <= r_pkt_cnt + 1'b1;
                    if ((w_crcerr | r_lenerr) && r_err_cnt != 16'hFFFF)
                        r_err_cnt <= r_err_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Short packets still pop their bits but never start the engine.
    always_comb begin
        BitRd    = '0;
        CrcDin   = 1'b0;
        CrcStart = 1'b0;
        CrcStop  = 1'b0;
        Done     = 1'b0;
        DoneLink = '0;
        CrcErr   = 1'b0;
        LenErr   = 1'b0;
        CrcRst   = Reset | (r_state == ARB);
        case (r_state)
            DATA: begin
                BitRd[r_gnt] = 1'b1;
                CrcDin       = Bit[r_gnt];
                CrcStart     = ~r_lenerr & (r_cnt == '0);
                CrcStop      = ~r_lenerr & (r_cnt == {1'b0, r_len} - 2'd2);
            end
            CRCB: BitRd[r_gnt] = 1'b1;
            CMP: begin
                Done     = 1'b1;
                DoneLink = 3'(r_gnt);
                CrcErr   = w_crcerr;
                LenErr   = r_lenerr;
            end
            default: ;
        endcase
    end

    assign PktCnt = r_pkt_cnt;
    assign ErrCnt = r_err_cnt;
endmodule

// File: tb/tb_crc_link_sequencer.sv
// Bench for crc_link_sequencer: link buffer models, a serial CRC-6 engine, and a
// packet-level reference (round-robin order, L+7 latency, golden CRC) checked per scenario.
module tb_crc_link_sequencer;
    localparam int NLINK = 4;
    localparam int LENW  = 12;

    logic                  Clock = 1'b0;
    logic                  Reset = 1'b1;
    logic [NLINK-1:0]      Req, Bit, BitRd;
    logic [NLINK*LENW-1:0] Len;
    logic                  CrcRst, CrcStart, CrcStop, CrcDin;
    logic [5:0]            CrcVal;
    logic                  Done, CrcErr, LenErr;
    logic [2:0]            DoneLink;
    logic [15:0]           PktCnt, ErrCnt;

    crc_link_sequencer #(.NLINK(NLINK), .LENW(LENW)) dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .Len(Len), .Bit(Bit), .BitRd(BitRd),
        .CrcRst(CrcRst), .CrcStart(CrcStart), .CrcStop(CrcStop), .CrcDin(CrcDin),
        .CrcVal(CrcVal), .Done(Done), .DoneLink(DoneLink), .CrcErr(CrcErr),
        .LenErr(LenErr), .PktCnt(PktCnt), .ErrCnt(ErrCnt)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Link buffers: FWFT bit FIFOs, written by the test tasks, popped by BitRd.
    bit lbuf [NLINK][256];
    int rdp   [NLINK] = '{default: 0};
    int wrp   [NLINK] = '{default: 0};
    int npend [NLINK] = '{default: 0};
    int ndone [NLINK] = '{default: 0};
    int lenv  [NLINK] = '{default: 0};

    always @(posedge Clock)
        for (int i = 0; i < NLINK; i++)
            if (BitRd[i]) rdp[i] <= rdp[i] + 1;

    always_comb begin
        Bit = '0;
        Req = '0;
        Len = '0;
        for (int i = 0; i < NLINK; i++) begin
            Bit[i] = lbuf[i][rdp[i] & 255];
            Req[i] = (npend[i] != ndone[i]);
            Len[i*LENW +: LENW] = lenv[i][LENW-1:0];
        end
    end

    // CRC-6, polynomial x^6+x+1, MSB first, zero seed.
    function automatic logic [5:0] step(input logic [5:0] c, input logic d);
        logic fb;
        fb = c[5] ^ d;
        return {c[4:0], 1'b0} ^ (fb ? 6'h03 : 6'h00);
    endfunction

    function automatic logic [5:0] crc6(input logic [63:0] p, input int L);
        logic [5:0] c;
        c = '0;
        for (int i = L-1; i >= 0; i--) c = step(c, p[i]);
        return c;
    endfunction

    // Serial engine: takes Din from the Start cycle through the cycle after Stop.
    logic [5:0] eng_crc = '0;
    logic       eng_on = 1'b0, eng_last = 1'b0;
    always @(posedge Clock) begin
        if (CrcRst) begin
            eng_crc <= '0; eng_on <= 1'b0; eng_last <= 1'b0;
        end else if (CrcStart) begin
            eng_crc <= step(6'd0, CrcDin); eng_on <= 1'b1; eng_last <= CrcStop;
        end else if (eng_on) begin
            eng_crc <= step(eng_crc, CrcDin);
            if (eng_last) eng_on <= 1'b0;
            else          eng_last <= CrcStop;
        end
    end
    assign CrcVal = eng_crc;

    int dq_cyc[$];
    int dq_link[$];
    bit dq_cerr[$];
    bit dq_lerr[$];
    int arb_cyc[$];
    int n_start = 0, n_both = 0, n_ohviol = 0;

    always @(negedge Clock) begin
        if (!Reset && CrcRst) arb_cyc.push_back(cyc);
        if (CrcStart) n_start <= n_start + 1;
        if (CrcStart && CrcStop) n_both <= n_both + 1;
        if ($countones(BitRd) > 1) n_ohviol <= n_ohviol + 1;
        if (Done) begin
            dq_cyc.push_back(cyc);
            dq_link.push_back(int'(DoneLink));
            dq_cerr.push_back(CrcErr);
            dq_lerr.push_back(LenErr);
            if (int'(DoneLink) < NLINK) ndone[DoneLink] <= ndone[DoneLink] + 1;
        end
    end

    task automatic tick();
        @(posedge Clock); #1;
    endtask

    task automatic flush_links();
        for (int i = 0; i < NLINK; i++) begin
            npend[i] = ndone[i];
            wrp[i]   = rdp[i];
            lenv[i]  = 0;
        end
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        repeat (3) tick();
        flush_links();
        Reset = 1'b0;
        tick();
    endtask

    task automatic load_pkt(input int link, input int L, input logic [63:0] pay, input bit flip);
        logic [5:0] tx;
        tx = crc6(pay, L);
        if (flip) tx = tx ^ (6'd1 << $urandom_range(0, 5));
        for (int b = L-1; b >= 0; b--) begin lbuf[link][wrp[link] & 255] = pay[b]; wrp[link]++; end
        for (int b = 5; b >= 0; b--)   begin lbuf[link][wrp[link] & 255] = tx[b];  wrp[link]++; end
        lenv[link] = L;
        npend[link]++;
    endtask

    task automatic wait_done(input int target, output bit to);
        int n;
        n = 0;
        while (dq_link.size() < target && n < 3000) begin tick(); n++; end
        to = (dq_link.size() < target);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) tick();
        total++; if (BitRd !== '0) begin bad++; $display("FAIL rst_bitrd got=%b exp=0", BitRd); end
        total++; if (CrcRst !== 1'b1) begin bad++; $display("FAIL rst_crcrst got=%b exp=1", CrcRst); end
        total++; if ({CrcStart, CrcStop, CrcDin} !== 3'b000) begin bad++; $display("FAIL rst_eng got=%b exp=000", {CrcStart, CrcStop, CrcDin}); end
        total++; if ({Done, CrcErr, LenErr, DoneLink} !== 6'd0) begin bad++; $display("FAIL rst_done got=%b exp=0", {Done, CrcErr, LenErr, DoneLink}); end
        total++; if ({PktCnt, ErrCnt} !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%h exp=0", {PktCnt, ErrCnt}); end
        flush_links();
        Reset = 1'b0;
        tick();
        total++; if (CrcRst !== 1'b0) begin bad++; $display("FAIL idle_crcrst got=%b exp=0", CrcRst); end
    endtask

    task automatic test_single(input bit flip);
        int base, abase, r0, s0;
        bit to;
        apply_reset();
        base = dq_link.size(); abase = arb_cyc.size(); r0 = rdp[0]; s0 = n_start;
        load_pkt(0, 16, 64'hA5C3, flip);
        wait_done(base + 1, to);
        total++; if (to) begin bad++; $display("FAIL single_timeout got=none exp=Done"); end
        if (!to) begin
            total++; if (dq_cyc[base] - arb_cyc[abase] != 23) begin bad++; $display("FAIL single_lat got=%0d exp=23", dq_cyc[base] - arb_cyc[abase]); end
            total++; if (dq_link[base] != 0) begin bad++; $display("FAIL single_link got=%0d exp=0", dq_link[base]); end
            total++; if (dq_cerr[base] != flip) begin bad++; $display("FAIL single_crcerr got=%0d exp=%0d", dq_cerr[base], flip); end
            total++; if (dq_lerr[base] != 1'b0) begin bad++; $display("FAIL single_lenerr got=%0d exp=0", dq_lerr[base]); end
        end
        repeat (3) tick();
        total++; if (PktCnt !== 16'd1) begin bad++; $display("FAIL single_pkt got=%0d exp=1", PktCnt); end
        total++; if (ErrCnt !== 16'(flip)) begin bad++; $display("FAIL single_err got=%0d exp=%0d", ErrCnt, flip); end
        total++; if (rdp[0] - r0 != 22) begin bad++; $display("FAIL single_pops got=%0d exp=22", rdp[0] - r0); end
        total++; if (n_start - s0 != 1) begin bad++; $display("FAIL single_starts got=%0d exp=1", n_start - s0); end
    endtask

    task automatic test_round_robin();
        int base, cnt[NLINK], fl[NLINK][2], used[NLINK], order[5], ptr, nerr, oh0;
        bit to;
        apply_reset();
        base = dq_link.size(); oh0 = n_ohviol; nerr = 0;
        for (int i = 0; i < NLINK; i++) begin
            cnt[i] = (i == 0) ? 2 : 1; used[i] = 0;
            for (int k = 0; k < cnt[i]; k++) begin
                fl[i][k] = $urandom_range(0, 1);
                nerr += fl[i][k];
                load_pkt(i, 8, 64'($urandom), fl[i][k] != 0);
            end
        end
        ptr = 0;
        for (int p = 0; p < 5; p++) begin
            for (int j = NLINK-1; j >= 0; j--)
                if (cnt[(ptr + j) % NLINK] > 0) order[p] = (ptr + j) % NLINK;
            cnt[order[p]]--;
            ptr = (order[p] + 1) % NLINK;
        end
        wait_done(base + 5, to);
        total++; if (to) begin bad++; $display("FAIL rr_timeout got=%0d exp=5", dq_link.size() - base); end
        if (!to) begin
            for (int p = 0; p < 5; p++) begin
                total++; if (dq_link[base+p] != order[p]) begin bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", p, dq_link[base+p], order[p]); end
                total++; if (dq_cerr[base+p] != (fl[order[p]][used[order[p]]] != 0)) begin bad++; $display("FAIL rr_crcerr[%0d] got=%0d exp=%0d", p, dq_cerr[base+p], fl[order[p]][used[order[p]]]); end
                used[order[p]]++;
                if (p > 0) begin
                    total++; if (dq_cyc[base+p] - dq_cyc[base+p-1] != 17) begin bad++; $display("FAIL rr_period[%0d] got=%0d exp=17", p, dq_cyc[base+p] - dq_cyc[base+p-1]); end
                end
            end
        end
        tick();
        total++; if (PktCnt !== 16'd5) begin bad++; $display("FAIL rr_pkt got=%0d exp=5", PktCnt); end
        total++; if (ErrCnt !== 16'(nerr)) begin bad++; $display("FAIL rr_err got=%0d exp=%0d", ErrCnt, nerr); end
        total++; if (n_ohviol != oh0) begin bad++; $display("FAIL rr_onehot got=%0d exp=0", n_ohviol - oh0); end
    endtask

    task automatic test_short_len();
        int base, abase, r0, s0, b0;
        bit flip, to;
        apply_reset();
        flip = 1'($urandom_range(0, 1));
        base = dq_link.size(); abase = arb_cyc.size(); r0 = rdp[2]; b0 = n_both;
        load_pkt(2, 2, 64'($urandom_range(0, 3)), flip);
        wait_done(base + 1, to);
        total++; if (to) begin bad++; $display("FAIL l2_timeout got=none exp=Done"); end
        if (!to) begin
            total++; if (dq_cyc[base] - arb_cyc[abase] != 9) begin bad++; $display("FAIL l2_lat got=%0d exp=9", dq_cyc[base] - arb_cyc[abase]); end
            total++; if (dq_cerr[base] != flip) begin bad++; $display("FAIL l2_crcerr got=%0d exp=%0d", dq_cerr[base], flip); end
            total++; if (dq_lerr[base] != 1'b0) begin bad++; $display("FAIL l2_lenerr got=%0d exp=0", dq_lerr[base]); end
        end
        total++; if (n_both - b0 != 1) begin bad++; $display("FAIL l2_startstop got=%0d exp=1", n_both - b0); end
        total++; if (rdp[2] - r0 != 8) begin bad++; $display("FAIL l2_pops got=%0d exp=8", rdp[2] - r0); end
        repeat (2) tick();
        base = dq_link.size(); abase = arb_cyc.size(); r0 = rdp[2]; s0 = n_start;
        load_pkt(2, 1, 64'($urandom_range(0, 1)), 1'b0);
        wait_done(base + 1, to);
        total++; if (to) begin bad++; $display("FAIL l1_timeout got=none exp=Done"); end
        if (!to) begin
            total++; if (dq_cyc[base] - arb_cyc[abase] != 8) begin bad++; $display("FAIL l1_lat got=%0d exp=8", dq_cyc[base] - arb_cyc[abase]); end
            total++; if (dq_lerr[base] != 1'b1) begin bad++; $display("FAIL l1_lenerr got=%0d exp=1", dq_lerr[base]); end
            total++; if (dq_cerr[base] != 1'b0) begin bad++; $display("FAIL l1_crcerr got=%0d exp=0", dq_cerr[base]); end
            total++; if (dq_link[base] != 2) begin bad++; $display("FAIL l1_link got=%0d exp=2", dq_link[base]); end
        end
        total++; if (rdp[2] - r0 != 7) begin bad++; $display("FAIL l1_pops got=%0d exp=7", rdp[2] - r0); end
        total++; if (n_start != s0) begin bad++; $display("FAIL l1_nostart got=%0d exp=0", n_start - s0); end
        tick();
        total++; if (ErrCnt !== 16'(flip) + 16'd1) begin bad++; $display("FAIL short_err got=%0d exp=%0d", ErrCnt, flip + 1); end
    endtask

    task automatic test_reset_mid();
        int base, abase, r0, n;
        apply_reset();
        base = dq_link.size(); abase = arb_cyc.size(); r0 = rdp[1];
        load_pkt(1, 40, {$urandom, $urandom}, 1'b0);
        n = 0;
        while (arb_cyc.size() == abase && n < 100) begin tick(); n++; end
        total++; if (arb_cyc.size() == abase) begin bad++; $display("FAIL mid_arb got=none exp=grant"); end
        repeat (5) tick();
        Reset = 1'b1;
        tick();
        total++; if (BitRd !== '0 || {CrcStart, CrcStop, CrcDin} !== 3'b000) begin bad++; $display("FAIL mid_outs got=%b/%b exp=0", BitRd, {CrcStart, CrcStop, CrcDin}); end
        total++; if ({Done, CrcErr, LenErr, DoneLink} !== 6'd0 || CrcRst !== 1'b1) begin bad++; $display("FAIL mid_done got=%b rst=%b exp=0/1", {Done, CrcErr, LenErr, DoneLink}, CrcRst); end
        total++; if ({PktCnt, ErrCnt} !== 32'd0) begin bad++; $display("FAIL mid_cnt got=%h exp=0", {PktCnt, ErrCnt}); end
        total++; if (rdp[1] - r0 != 6) begin bad++; $display("FAIL mid_pops got=%0d exp=6", rdp[1] - r0); end
        flush_links();
        Reset = 1'b0;
        tick();
        total++; if (CrcRst !== 1'b0) begin bad++; $display("FAIL mid_idle got=%b exp=0", CrcRst); end
        repeat (60) tick();
        total++; if (dq_link.size() != base) begin bad++; $display("FAIL mid_nodone got=%0d exp=0", dq_link.size() - base); end
    endtask

    task automatic test_counters();
        int base;
        bit to;
        apply_reset();
        // Preload both counters near the top instead of running 65535 packets.
        force dut.r_pkt_cnt = 16'hFFFE;
        force dut.r_err_cnt = 16'hFFFE;
        #1;
        release dut.r_pkt_cnt;
        release dut.r_err_cnt;
        tick();
        total++; if ({PktCnt, ErrCnt} !== 32'hFFFE_FFFE) begin bad++; $display("FAIL cnt_preload got=%h exp=fffefffe", {PktCnt, ErrCnt}); end
        base = dq_link.size();
        load_pkt(3, 1, 64'd1, 1'b0);
        wait_done(base + 1, to);
        total++; if (to || PktCnt !== 16'hFFFF || ErrCnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_top got=%h/%h exp=ffff/ffff", PktCnt, ErrCnt); end
        repeat (2) tick();
        load_pkt(3, 4, 64'($urandom_range(0, 15)), 1'b1);
        wait_done(base + 2, to);
        total++; if (to || PktCnt !== 16'h0000 || ErrCnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_wrap got=%h/%h exp=0000/ffff", PktCnt, ErrCnt); end
        total++; if (!to && dq_cerr[base+1] != 1'b1) begin bad++; $display("FAIL cnt_crcerr got=0 exp=1"); end
        repeat (2) tick();
        load_pkt(3, 4, 64'($urandom_range(0, 15)), 1'b0);
        wait_done(base + 3, to);
        total++; if (to || PktCnt !== 16'h0001 || ErrCnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_after got=%h/%h exp=0001/ffff", PktCnt, ErrCnt); end
    endtask

    initial begin
        test_reset();
        test_single(1'b0);
        test_single(1'b1);
        test_round_robin();
        test_short_len();
        test_reset_mid();
        test_counters();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
